// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, WIDTH steps per operation.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic             last;

   // Multiply keeps the multiplicand here, divide keeps the divisor.
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_quo;

   // One iteration of each algorithm, computed from the current working registers.
   always_comb begin
      last      = (cnt == CW'(WIDTH - 1));
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, operand};
      if (!div_trial[WIDTH]) begin
         div_rem = div_trial[WIDTH-1:0];
         div_quo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         div_rem = div_shift[WIDTH-1:0];
         div_quo = {acc_lo[WIDTH-2:0], 1'b0};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; DONE always falls back to IDLE so start held high is not re-accepted there.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = op ? DIV : MUL;
         MUL:     if (last) state_next = DONE;
         DIV:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == MUL) || (state == DIV);
   assign done = (state == DONE);

   // Working registers and HI/LO; HI/LO only change on the final iteration edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         operand <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  operand <= op ? b : a;
                  acc_hi  <= '0;
                  acc_lo  <= op ? a : b;
               end
            end
            MUL: begin
               cnt    <= cnt + 1'b1;
               acc_hi <= mul_hi;
               acc_lo <= mul_lo;
               if (last) begin
                  hi <= mul_hi;
                  lo <= mul_lo;
               end
            end
            DIV: begin
               cnt    <= cnt + 1'b1;
               acc_hi <= div_rem;
               acc_lo <= div_quo;
               if (last) begin
                  hi <= div_rem;
                  lo <= div_quo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level arithmetic model checked every cycle,
// plus directed operations with hand-computed HI/LO results and latency checks.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Behavioural model: results come from plain arithmetic, timing from a remaining-cycles count.
   logic             exp_busy = 1'b0;
   logic             exp_done = 1'b0;
   logic [WIDTH-1:0] exp_hi   = '0;
   logic [WIDTH-1:0] exp_lo   = '0;
   logic [WIDTH-1:0] pend_hi  = '0;
   logic [WIDTH-1:0] pend_lo  = '0;
   logic [63:0]      product;
   int               remaining = 0;

   always @(posedge clk) begin
      if (reset) begin
         exp_busy  = 1'b0;
         exp_done  = 1'b0;
         exp_hi    = '0;
         exp_lo    = '0;
         remaining = 0;
      end else if (exp_busy) begin
         remaining = remaining - 1;
         if (remaining == 0) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
            exp_hi   = pend_hi;
            exp_lo   = pend_lo;
         end
      end else if (exp_done) begin
         exp_done = 1'b0;
      end else if (start) begin
         if (!op) begin
            product = {32'b0, a} * {32'b0, b};
            pend_hi = product[63:32];
            pend_lo = product[31:0];
         end else if (b == 0) begin
            pend_hi = a;
            pend_lo = '1;
         end else begin
            pend_hi = a % b;
            pend_lo = a / b;
         end
         remaining = WIDTH;
         exp_busy  = 1'b1;
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (checking) begin
         checks = checks + 1;
         if (busy !== exp_busy || done !== exp_done || hi !== exp_hi || lo !== exp_lo) begin
            errors = errors + 1;
            $display("[TB] FAIL model_cycle t=%0t: busy=%b done=%b hi=%h lo=%h, required busy=%b done=%b hi=%h lo=%h",
                     $time, busy, done, hi, lo, exp_busy, exp_done, exp_hi, exp_lo);
         end
      end
   end

   task automatic expectEq(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks = checks + 1;
      if (actual !== required) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
      end
   endtask

   // Issues a one-cycle start; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done, checks busy-window length and HI/LO, then checks return to idle.
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] ehi,
                              input logic [WIDTH-1:0] elo, input bit scramble);
      int busyCycles = 0;
      int guard = 0;
      while (!done && guard < 100) begin
         if (busy) busyCycles++;
         if (scramble) begin
            a = $urandom;
            b = $urandom;
         end
         @(negedge clk);
         guard++;
      end
      if (!done) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL %s_timeout: done never rose within %0d cycles", name, guard);
      end else begin
         expectEq({name, "_latency"}, 64'(busyCycles), 64'(WIDTH));
         expectEq({name, "_hi"}, 64'(hi), 64'(ehi));
         expectEq({name, "_lo"}, 64'(lo), 64'(elo));
      end
      @(negedge clk);
      expectEq({name, "_idle"}, {62'b0, busy, done}, 64'd0);
   endtask

   initial begin
      int guard;
      int pulses;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      checking = 1'b1;
      expectEq("reset_state", {busy, done, hi, lo}, 66'd0);
      reset = 1'b0;

      applyStimulus(1'b0, 32'd7, 32'd6);
      expectEq("busy_after_accept", 64'(busy), 64'd1);
      checkOutput("mul_7x6", 32'h0000_0000, 32'h0000_002A, 1'b0);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("mul_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

      applyStimulus(1'b1, 32'd100, 32'd7);
      checkOutput("div_100_7", 32'd2, 32'd14, 1'b0);

      applyStimulus(1'b1, 32'h1234_5678, 32'd0);
      checkOutput("div_by_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);

      // start held high across a whole operation and its DONE cycle
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      a     = 32'd3;
      b     = 32'd5;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!done && guard < 100);
      if (!done) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL hold_timeout: done never rose within %0d cycles", guard);
      end
      expectEq("hold_first_result", {hi, lo}, {32'd0, 32'd15});
      a = 32'd4;
      b = 32'd5;
      @(negedge clk);
      expectEq("hold_done_ignored", {62'b0, busy, done}, 64'd0);
      @(negedge clk);
      expectEq("hold_second_accept", 64'(busy), 64'd1);
      expectEq("hold_old_hilo", {hi, lo}, {32'd0, 32'd15});
      start = 1'b0;
      checkOutput("hold_second", 32'd0, 32'd20, 1'b0);

      // reset during iteration 10 of a divide
      applyStimulus(1'b1, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expectEq("abort_cleared", {busy, done, hi, lo}, 66'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      expectEq("abort_no_done", 64'(pulses), 64'd0);

      applyStimulus(1'b0, 32'd9, 32'd9);
      checkOutput("mul_9x9_scrambled", 32'd0, 32'd81, 1'b1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative unsigned multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the instruction decoder, alongside the ALU. It executes mulu/divu (ALU control codes 011/111) over multiple cycles and supplies HI/LO for mfhi/mflo (100/101). The datapath stalls the PC while `busy` is high.

Parameters:
- WIDTH, 32, operand width; also the number of iteration cycles per operation.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  1  0 = multiply (mulu), 1 = divide (divu).
- a  in  WIDTH  rs operand: multiplicand or dividend.
- b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  high while iterating (MUL or DIV state).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (synchronous, has priority over everything):
  - state goes to IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Counter and working registers are cleared.
  - Reset mid-operation aborts the operation. HI/LO become 0, never partial values.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: at an edge with start=1, latch a and b, clear the counter, go to MUL (op=0) or DIV (op=1). With start=0, stay in IDLE.
  - MUL/DIV: perform one iteration per edge and increment the counter. At the edge completing iteration WIDTH, write HI/LO and go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE unconditionally. start is ignored in DONE; the stalled instruction still drives start in this cycle.
- Outputs:
  - busy = (state==MUL || state==DIV), registered state decode.
  - done = (state==DONE).
- Latency: start accepted at edge k → busy high for cycles k..k+WIDTH-1 → HI/LO updated and done high after edge k+WIDTH, i.e. WIDTH+1 cycles from acceptance to IDLE.
- start while busy or in DONE: ignored; latched operands are unaffected.
- a/b may change after acceptance without effect.
- Multiply (unsigned shift-add):
  - 2*WIDTH-bit accumulator {P, M}, with M initialised to b and P to 0.
  - Each cycle: if M[0], P += a, with a WIDTH+1-bit sum keeping the carry. Then shift {carry, P, M} right by 1.
  - Final: hi = P, lo = M. The full 64-bit product is exact with no overflow.
- Divide (unsigned restoring):
  - Remainder R (WIDTH+1 bits) starts at 0; quotient Q starts at a.
  - Each cycle: shift {R, Q} left by 1, trial T = R - {0, b}.
    - If T is non-negative: R = T and Q[0] = 1.
    - Otherwise: R is kept and Q[0] = 0.
  - Final: hi = R[WIDTH-1:0], lo = Q.
- Divide by zero: not special-cased. The algorithm naturally yields lo = all ones and hi = a, with the same latency. This behaviour is required.
- HI/LO are written only in the DONE-transition cycle. During busy they keep the previous result, so an mfhi/mflo read while busy returns the old values.
- Counter width: clog2(WIDTH)+1 bits. There is no wrap-around, because the counter is cleared on every acceptance.

Test Plan:
- Reset, then start op=0, a=7, b=6 → busy for 32 cycles; done pulse on the 33rd cycle after acceptance; hi=0x00000000, lo=0x0000002A; IDLE the next cycle.
- op=0, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- op=1, a=100, b=7 → lo=14, hi=2. Then op=1, a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678, with the same 32-cycle latency.
- Hold start=1 continuously through a multiply (a=3, b=5):
  - exactly one operation runs;
  - start is ignored in DONE;
  - a new operation is accepted on the cycle after DONE;
  - hi/lo stay at the old values (0/15 after the first) during the second busy window.
- Assert reset at iteration 10 of divu 100/7 → next cycle: busy=0, done=0, hi=0, lo=0, state IDLE; no done pulse follows.
- Change a and b every cycle while busy for mulu 9*9 → lo=81, hi=0.
